scan_driver: RTL and testbench

Parametrised multiplexed 7-segment display driver, and the next generation of the fixed 8-digit one-hot scanner.
- Adds configurable digit count and dwell time per digit.
- Skips disabled digits via a mask and inserts an anti-ghosting blanking interval.
- Integrates hex-to-segment decode and emits a frame-wrap strobe.
- Sits between the display data registers and the board-level digit-select and segment pins.

---
 rtl/scan_pkg.sv | 27 ++
 rtl/seg7_decode.sv | 12 +
 rtl/scan_driver.sv | 188 ++++++++++++++++++
 tb/tb_scan_driver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the multiplexed 7-segment display path: scan states,
// active-high hex segment codes and a constant-safe clog2.
package scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // Index n holds the {g,f,e,d,c,b,a} pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Never returns less than 1 so it can size a vector directly.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble plus decimal point to active-high {dp,g,f,e,d,c,b,a} code.
module seg7_decode
    import scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       point,
    output logic [7:0] code
);

    assign code = {point, SEG_HEX[nibble]};

endmodule

// File: rtl/scan_driver.sv
// Multiplexed 7-segment scanner: rotates over enabled digits with a fixed slot
// length, blanks the start of each slot, and pulses frame on every scan wrap.
//
// state   | meaning
// S_IDLE  | scan stopped (en low or no digit enabled), outputs off, idx held
// S_BLANK | first BLANK cycles of a slot, everything off to stop ghosting
// S_DRIVE | remainder of the slot, digit idx lit with its latched code
module scan_driver
    import scan_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int DIV            = 1000,
    parameter int BLANK          = 2,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clks,
    input  logic                      rsts,
    input  logic                      en,
    input  logic [DIGITS-1:0]         digit_mask,
    input  logic [4*DIGITS-1:0]       data,
    input  logic [DIGITS-1:0]         dp,
    output logic [DIGITS-1:0]         sel,
    output logic [7:0]                seg,
    output logic [clog2(DIGITS)-1:0]  idx,
    output logic                      frame
);

    localparam int IW = clog2(DIGITS);
    localparam int CW = clog2(DIV);
    localparam logic [DIGITS-1:0] SEL_POL  = {DIGITS{SEL_ACTIVE_LOW}};
    localparam logic [7:0]        SEG_POL  = {8{SEG_ACTIVE_LOW}};
    localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]     BLK_LAST = CW'(BLANK - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic [DIGITS-1:0] sel_raw;
    logic [7:0]        seg_raw;

    logic [IW-1:0]     idx_first;
    logic [IW-1:0]     idx_next;
    logic [IW-1:0]     pick_idx;
    logic [3:0]        new_nib;
    logic              new_dp;
    logic [3:0]        dec_nib;
    logic              dec_dp;
    logic [7:0]        dec_code;
    logic [DIGITS-1:0] sel_cur;
    logic [DIGITS-1:0] sel_new;

    // Rotating priority search: first enabled digit at or after 'from'
    // (incl=1) or strictly after it (incl=0), wrapping; 'from' itself is the
    // last candidate in the exclusive case so a lone digit re-selects itself.
    function automatic logic [IW-1:0] next_enabled(
        input logic [DIGITS-1:0] m,
        input logic [IW-1:0]     from,
        input logic              incl
    );
        logic [IW-1:0] r;
        logic [IW-1:0] ci;
        logic          found;
        int            off;
        int            c;
        r     = from;
        found = 1'b0;
        off   = incl ? 0 : 1;
        for (int k = 0; k < DIGITS; k++) begin
            c  = (int'(from) + k + off) % DIGITS;
            ci = IW'(c);
            if (!found && m[ci]) begin
                r     = ci;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign idx_first = next_enabled(digit_mask, idx, 1'b1);
    assign idx_next  = next_enabled(digit_mask, idx, 1'b0);
    assign pick_idx  = (state == S_IDLE) ? idx_first : idx_next;

    assign new_nib = data[{pick_idx, 2'b00} +: 4];
    assign new_dp  = dp[pick_idx];

    // Without a blanking phase the new digit is driven on the same edge it is
    // picked, so the decoder must see the incoming nibble, not the latched one.
    assign dec_nib = (BLANK == 0) ? new_nib : cur_nib;
    assign dec_dp  = (BLANK == 0) ? new_dp  : cur_dp;

    assign sel_cur = DIGITS'(1) << idx;
    assign sel_new = DIGITS'(1) << pick_idx;

    seg7_decode u_decode (
        .nibble (dec_nib),
        .point  (dec_dp),
        .code   (dec_code)
    );

    always_ff @(posedge clks or posedge rsts) begin
        if (rsts) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            frame   <= 1'b0;
            cur_nib <= '0;
            cur_dp  <= 1'b0;
            sel_raw <= '0;
            seg_raw <= '0;
        end else begin
            frame <= 1'b0;
            if (!en) begin
                state   <= S_IDLE;
                cnt     <= '0;
                sel_raw <= '0;
                seg_raw <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        cnt     <= '0;
                        sel_raw <= '0;
                        seg_raw <= '0;
                        if (digit_mask != '0) begin
                            idx     <= idx_first;
                            cur_nib <= new_nib;
                            cur_dp  <= new_dp;
                            if (BLANK == 0) begin
                                state   <= S_DRIVE;
                                sel_raw <= sel_new;
                                seg_raw <= dec_code;
                            end else begin
                                state   <= S_BLANK;
                            end
                        end
                    end

                    S_BLANK: begin
                        cnt <= cnt + CW'(1);
                        if (cnt == BLK_LAST) begin
                            state   <= S_DRIVE;
                            sel_raw <= sel_cur;
                            seg_raw <= dec_code;
                        end
                    end

                    S_DRIVE: begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (digit_mask == '0) begin
                                state   <= S_IDLE;
                                sel_raw <= '0;
                                seg_raw <= '0;
                            end else begin
                                idx     <= idx_next;
                                frame   <= (idx_next <= idx);
                                cur_nib <= new_nib;
                                cur_dp  <= new_dp;
                                if (BLANK == 0) begin
                                    sel_raw <= sel_new;
                                    seg_raw <= dec_code;
                                end else begin
                                    state   <= S_BLANK;
                                    sel_raw <= '0;
                                    seg_raw <= '0;
                                end
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end

                    default: begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        sel_raw <= '0;
                        seg_raw <= '0;
                    end
                endcase
            end
        end
    end

    assign sel = sel_raw ^ SEL_POL;
    assign seg = seg_raw ^ SEG_POL;

endmodule

// File: tb/tb_scan_driver.sv
// Bench for scan_driver (8 digits, 4-cycle slots, 1 blank cycle, active-low)
// against a slot-level model of the scan schedule.
module tb_scan_driver;

    localparam int DIGITS = 8;
    localparam int DIV    = 4;
    localparam int BLANK  = 1;

    logic        clks = 1'b0;
    logic        rsts = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  digit_mask = 8'h00;
    logic [31:0] data = 32'h0;
    logic [7:0]  dp = 8'h00;
    logic [7:0]  sel;
    logic [7:0]  seg;
    logic [2:0]  idx;
    logic        frame;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [6:0] hex_code [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: is a scan running, position inside the current slot, which digit
    // owns the slot, what was captured at slot start, and whether it wrapped.
    bit         m_run = 0;
    int         m_pos = 0;
    int         m_dig = 0;
    logic [3:0] m_nib = 4'h0;
    bit         m_dp = 0;
    bit         m_frame = 0;

    scan_driver #(
        .DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK),
        .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clks(clks), .rsts(rsts), .en(en), .digit_mask(digit_mask),
        .data(data), .dp(dp), .sel(sel), .seg(seg), .idx(idx), .frame(frame)
    );

    always #5 clks = ~clks;

    function automatic int pick(input logic [7:0] m, input int from, input bit incl);
        int c;
        for (int k = 0; k < DIGITS; k++) begin
            c = (from + k + (incl ? 0 : 1)) % DIGITS;
            if (m[c]) return c;
        end
        return from;
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [7:0] s;
        logic [7:0] g;
        bit lit;
        lit = m_run && (m_pos >= BLANK);
        s = lit ? ~(8'h01 << m_dig) : 8'hFF;
        g = lit ? ~{m_dp, hex_code[m_nib]} : 8'hFF;
        return {s, g, 3'(m_dig), m_frame};
    endfunction

    task automatic tick();
        int nd;
        @(posedge clks);
        cyc++;
        if (rsts) begin
            m_run = 0; m_pos = 0; m_dig = 0; m_frame = 0;
        end else begin
            m_frame = 0;
            if (!en) begin
                m_run = 0; m_pos = 0;
            end else if (!m_run) begin
                if (digit_mask != 0) begin
                    m_dig = pick(digit_mask, m_dig, 1);
                    m_run = 1; m_pos = 0;
                    m_nib = data[m_dig*4 +: 4]; m_dp = dp[m_dig];
                end
            end else begin
                m_pos++;
                if (m_pos == DIV) begin
                    m_pos = 0;
                    if (digit_mask == 0) m_run = 0;
                    else begin
                        nd = pick(digit_mask, m_dig, 0);
                        m_frame = (nd <= m_dig);
                        m_dig = nd;
                        m_nib = data[m_dig*4 +: 4]; m_dp = dp[m_dig];
                    end
                end
            end
        end
        @(negedge clks);
    endtask

    task automatic test_reset();
        rsts = 1'b1;
        tick(); tick();
        total++;
        if ({sel, seg, idx, frame} !== {8'hFF, 8'hFF, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset: sel=%h seg=%h idx=%0d frame=%0d, want FF FF 0 0", sel, seg, idx, frame);
        end
        rsts = 1'b0;
        tick();
    endtask

    task automatic test_full_scan();
        int last_frame = -1;
        int nframes = 0;
        en = 1'b1; digit_mask = 8'hFF; data = 32'h7654_3210; dp = 8'h00;
        for (int i = 0; i < 72; i++) begin
            tick();
            total++;
            if ({sel, seg, idx, frame} !== exp_vec()) begin
                bad++;
                $display("FAIL full_scan cyc=%0d got sel=%h seg=%h idx=%0d frame=%0d want %h", cyc, sel, seg, idx, frame, exp_vec());
            end
            if (frame) begin
                if (last_frame >= 0) begin
                    total++;
                    if (cyc - last_frame != DIGITS*DIV) begin
                        bad++;
                        $display("FAIL frame_period got %0d want %0d", cyc - last_frame, DIGITS*DIV);
                    end
                end
                last_frame = cyc;
                nframes++;
            end
        end
        total++;
        if (nframes != 2) begin
            bad++;
            $display("FAIL frame_count got %0d want 2", nframes);
        end
    endtask

    task automatic test_sparse_mask();
        digit_mask = 8'h05;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if ({sel, seg, idx, frame} !== exp_vec()) begin
                bad++;
                $display("FAIL sparse_mask cyc=%0d got sel=%h seg=%h idx=%0d frame=%0d want %h", cyc, sel, seg, idx, frame, exp_vec());
            end
        end
    endtask

    task automatic test_mask_zero();
        int n = 0;
        while (!(m_run && m_pos == BLANK) && n < 20) begin tick(); n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL mask_zero_wait got timeout want drive phase"); end
        digit_mask = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({sel, seg, idx, frame} !== exp_vec()) begin
                bad++;
                $display("FAIL mask_zero cyc=%0d got sel=%h seg=%h idx=%0d frame=%0d want %h", cyc, sel, seg, idx, frame, exp_vec());
            end
        end
        digit_mask = 8'h80;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if ({sel, seg, idx, frame} !== exp_vec()) begin
                bad++;
                $display("FAIL mask_single cyc=%0d got sel=%h seg=%h idx=%0d frame=%0d want %h", cyc, sel, seg, idx, frame, exp_vec());
            end
        end
    endtask

    task automatic test_en_drop();
        int n = 0;
        digit_mask = 8'hFF;
        while (!(m_run && m_dig == 3 && m_pos == BLANK + 1) && n < 80) begin tick(); n++; end
        total++;
        if (n >= 80) begin bad++; $display("FAIL en_drop_wait got timeout want idx 3 drive"); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({sel, seg, idx, frame} !== exp_vec()) begin
                bad++;
                $display("FAIL en_drop cyc=%0d got sel=%h seg=%h idx=%0d frame=%0d want %h", cyc, sel, seg, idx, frame, exp_vec());
            end
        end
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({sel, seg, idx, frame} !== exp_vec()) begin
                bad++;
                $display("FAIL en_resume cyc=%0d got sel=%h seg=%h idx=%0d frame=%0d want %h", cyc, sel, seg, idx, frame, exp_vec());
            end
        end
    endtask

    task automatic test_no_tear();
        int n = 0;
        logic [7:0] held;
        while (!(m_run && m_pos == BLANK) && n < 20) begin tick(); n++; end
        held = seg;
        data[m_dig*4 +: 4] = data[m_dig*4 +: 4] + 4'd5;
        dp[m_dig] = ~dp[m_dig];
        for (int i = 0; i < DIV - BLANK - 1; i++) begin
            tick();
            total++;
            if (seg !== held) begin
                bad++;
                $display("FAIL no_tear cyc=%0d got seg=%h want %h", cyc, seg, held);
            end
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if ({sel, seg, idx, frame} !== exp_vec()) begin
                bad++;
                $display("FAIL after_tear cyc=%0d got sel=%h seg=%h idx=%0d frame=%0d want %h", cyc, sel, seg, idx, frame, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (!(m_run && m_pos == BLANK + 1) && n < 20) begin tick(); n++; end
        #2 rsts = 1'b1;
        #1;
        total++;
        if ({sel, seg, idx, frame} !== {8'hFF, 8'hFF, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: sel=%h seg=%h idx=%0d frame=%0d, want FF FF 0 0", sel, seg, idx, frame);
        end
        m_run = 0; m_pos = 0; m_dig = 0; m_frame = 0;
        tick();
        rsts = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if ({sel, seg, idx, frame} !== exp_vec()) begin
                bad++;
                $display("FAIL post_reset cyc=%0d got sel=%h seg=%h idx=%0d frame=%0d want %h", cyc, sel, seg, idx, frame, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 19) != 0);
            data = $urandom;
            dp   = 8'($urandom);
            if ($urandom_range(0, 9) == 0) digit_mask = 8'($urandom);
            tick();
            total++;
            if ({sel, seg, idx, frame} !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got sel=%h seg=%h idx=%0d frame=%0d want %h", cyc, sel, seg, idx, frame, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_mask_zero();
        test_en_drop();
        test_no_tear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
